// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO of any depth, with threshold flags, occupancy count, sticky error flags, flush, and optional FWFT read.
// Latency: one cycle in standard mode; in FWFT mode the head word shows on dout the cycle after it is written. wr_en is refused when full unless rd_en frees a slot in the same cycle.
module sync_fifo_flags #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int AF_THRESH  = 14,
    parameter int AE_THRESH  = 2,
    parameter int FWFT       = 0
) (
    input  logic                         clk,
    input  logic                         rst_,
    input  logic                         flush,
    input  logic                         wr_en,
    input  logic [DATA_WIDTH-1:0]        din,
    input  logic                         rd_en,
    output logic [DATA_WIDTH-1:0]        dout,
    output logic                         full,
    output logic                         empty,
    output logic                         almost_full,
    output logic                         almost_empty,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         overflow,
    output logic                         underflow
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [CW-1:0]         count_nxt;
    logic                  wr_acc;
    logic                  rd_acc;

    // Non-power-of-2 depths need an explicit wrap rather than natural rollover.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full         = (count == CW'(DEPTH));
    assign empty        = (count == '0);
    assign almost_full  = (count >= CW'(AF_THRESH));
    assign almost_empty = (count <= CW'(AE_THRESH));

    assign wr_acc = wr_en & (~full | rd_en) & ~flush;
    assign rd_acc = rd_en & ~empty & ~flush;

    always_comb begin
        count_nxt = count;
        if (wr_acc && !rd_acc)
            count_nxt = count + CW'(1);
        else if (rd_acc && !wr_acc)
            count_nxt = count - CW'(1);
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_acc)
                wr_ptr <= ptr_inc(wr_ptr);
            if (rd_acc)
                rd_ptr <= ptr_inc(rd_ptr);
            count <= count_nxt;
            if (wr_en && full && !rd_en)
                overflow <= 1'b1;
            if (rd_en && empty)
                underflow <= 1'b1;
        end
    end

    // Storage is left unreset; the pointers and count alone define validity.
    always_ff @(posedge clk) begin
        if (wr_acc)
            mem[wr_ptr] <= din;
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign dout = empty ? '0 : mem[rd_ptr];
        end else begin : g_std
            logic [DATA_WIDTH-1:0] dout_q;
            always_ff @(posedge clk or negedge rst_) begin
                if (!rst_)
                    dout_q <= '0;
                else if (rd_acc)
                    dout_q <= mem[rd_ptr];
            end
            assign dout = dout_q;
        end
    endgenerate

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Directed bench: a 16-deep standard-read FIFO and a 5-deep FWFT FIFO.
module tb_sync_fifo_flags;

    logic       clk = 1'b0;
    logic       rst_ = 1'b0;

    logic       a_flush = 1'b0, a_wr = 1'b0, a_rd = 1'b0;
    logic [7:0] a_din = '0, a_dout;
    logic       a_full, a_empty, a_af, a_ae, a_ovf, a_udf;
    logic [4:0] a_count;

    logic       b_flush = 1'b0, b_wr = 1'b0, b_rd = 1'b0;
    logic [7:0] b_din = '0, b_dout;
    logic       b_full, b_empty, b_af, b_ae, b_ovf, b_udf;
    logic [2:0] b_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sync_fifo_flags #(.DATA_WIDTH(8), .DEPTH(16), .AF_THRESH(14), .AE_THRESH(2), .FWFT(0)) u_std (
        .clk(clk), .rst_(rst_), .flush(a_flush), .wr_en(a_wr), .din(a_din), .rd_en(a_rd),
        .dout(a_dout), .full(a_full), .empty(a_empty), .almost_full(a_af), .almost_empty(a_ae),
        .count(a_count), .overflow(a_ovf), .underflow(a_udf));

    sync_fifo_flags #(.DATA_WIDTH(8), .DEPTH(5), .AF_THRESH(4), .AE_THRESH(1), .FWFT(1)) u_fwft (
        .clk(clk), .rst_(rst_), .flush(b_flush), .wr_en(b_wr), .din(b_din), .rd_en(b_rd),
        .dout(b_dout), .full(b_full), .empty(b_empty), .almost_full(b_af), .almost_empty(b_ae),
        .count(b_count), .overflow(b_ovf), .underflow(b_udf));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #12;
        checks++; if ({a_count, a_empty, a_full, a_ae, a_af} !== {5'd0, 1'b1, 1'b0, 1'b1, 1'b0}) begin
            errors++; $display("FAIL reset_status got cnt=%0d e=%b f=%b ae=%b af=%b exp cnt=0 e=1 f=0 ae=1 af=0",
                               a_count, a_empty, a_full, a_ae, a_af); end
        checks++; if ({a_dout, a_ovf, a_udf} !== {8'h00, 1'b0, 1'b0}) begin
            errors++; $display("FAIL reset_dout_flags got dout=%h ovf=%b udf=%b exp 00 0 0", a_dout, a_ovf, a_udf); end
        checks++; if ({b_empty, b_dout, b_count} !== {1'b1, 8'h00, 3'd0}) begin
            errors++; $display("FAIL reset_fwft got e=%b dout=%h cnt=%0d exp 1 00 0", b_empty, b_dout, b_count); end
        rst_ = 1'b1;
        tick();
    endtask

    task automatic test_fill_overflow();
        for (int i = 0; i < 16; i++) begin
            a_wr = 1'b1; a_din = 8'(i);
            tick();
            checks++; if ({a_count, a_af, a_full, a_ae} !== {5'(i + 1), (i + 1 >= 14), (i + 1 == 16), (i + 1 <= 2)}) begin
                errors++; $display("FAIL fill[%0d] got cnt=%0d af=%b f=%b ae=%b exp cnt=%0d af=%b f=%b ae=%b", i,
                                   a_count, a_af, a_full, a_ae, i + 1, (i + 1 >= 14), (i + 1 == 16), (i + 1 <= 2)); end
        end
        a_din = 8'h10;
        tick();
        a_wr = 1'b0;
        checks++; if ({a_ovf, a_count, a_full, a_udf} !== {1'b1, 5'd16, 1'b1, 1'b0}) begin
            errors++; $display("FAIL overflow got ovf=%b cnt=%0d f=%b udf=%b exp 1 16 1 0", a_ovf, a_count, a_full, a_udf); end
    endtask

    task automatic test_drain_underflow();
        a_rd = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick();
            checks++; if ({a_dout, a_count} !== {8'(i), 5'(15 - i)}) begin
                errors++; $display("FAIL drain[%0d] got dout=%h cnt=%0d exp dout=%h cnt=%0d", i, a_dout, a_count, i, 15 - i); end
        end
        tick();
        a_rd = 1'b0;
        checks++; if ({a_udf, a_ovf, a_empty, a_dout} !== {1'b1, 1'b1, 1'b1, 8'h0F}) begin
            errors++; $display("FAIL underflow got udf=%b ovf=%b e=%b dout=%h exp 1 1 1 0f", a_udf, a_ovf, a_empty, a_dout); end
    endtask

    task automatic test_full_rw();
        a_flush = 1'b1;
        tick();
        a_flush = 1'b0;
        checks++; if ({a_ovf, a_udf, a_count} !== {1'b0, 1'b0, 5'd0}) begin
            errors++; $display("FAIL flush_clear got ovf=%b udf=%b cnt=%0d exp 0 0 0", a_ovf, a_udf, a_count); end
        a_wr = 1'b1;
        for (int i = 0; i < 16; i++) begin
            a_din = 8'(i);
            tick();
        end
        a_rd = 1'b1; a_din = 8'hAA;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++; if ({a_dout, a_count, a_ovf} !== {8'(k), 5'd16, 1'b0}) begin
                errors++; $display("FAIL full_rw[%0d] got dout=%h cnt=%0d ovf=%b exp %h 16 0", k, a_dout, a_count, a_ovf, k); end
        end
        a_wr = 1'b0;
        for (int j = 3; j < 19; j++) begin
            tick();
            checks++; if (a_dout !== ((j < 16) ? 8'(j) : 8'hAA)) begin
                errors++; $display("FAIL full_rw_tail[%0d] got %h exp %h", j, a_dout, (j < 16) ? 8'(j) : 8'hAA); end
        end
        a_rd = 1'b0;
        checks++; if (a_empty !== 1'b1) begin
            errors++; $display("FAIL full_rw_empty got %b exp 1", a_empty); end
    endtask

    task automatic test_empty_rw();
        a_wr = 1'b1; a_rd = 1'b1; a_din = 8'h55;
        tick();
        a_wr = 1'b0;
        checks++; if ({a_count, a_udf, a_dout} !== {5'd1, 1'b1, 8'hAA}) begin
            errors++; $display("FAIL empty_rw got cnt=%0d udf=%b dout=%h exp 1 1 aa", a_count, a_udf, a_dout); end
        tick();
        a_rd = 1'b0;
        checks++; if ({a_dout, a_count} !== {8'h55, 5'd0}) begin
            errors++; $display("FAIL empty_rw_read got dout=%h cnt=%0d exp 55 0", a_dout, a_count); end
    endtask

    task automatic test_fwft_wrap();
        b_wr = 1'b1; b_din = 8'h40;
        tick();
        checks++; if ({b_dout, b_count, b_empty} !== {8'h40, 3'd1, 1'b0}) begin
            errors++; $display("FAIL fwft_first got dout=%h cnt=%0d e=%b exp 40 1 0", b_dout, b_count, b_empty); end
        b_din = 8'h41;
        tick();
        b_rd = 1'b1;
        for (int k = 0; k < 12; k++) begin
            b_din = 8'(8'h42 + k);
            checks++; if (b_dout !== 8'(8'h40 + k)) begin
                errors++; $display("FAIL fwft_head[%0d] got %h exp %h", k, b_dout, 8'(8'h40 + k)); end
            tick();
            checks++; if ({b_dout, b_count, b_af, b_ae} !== {8'(8'h41 + k), 3'd2, 1'b0, 1'b0}) begin
                errors++; $display("FAIL fwft_pair[%0d] got dout=%h cnt=%0d af=%b ae=%b exp %h 2 0 0", k, b_dout, b_count,
                                   b_af, b_ae, 8'(8'h41 + k)); end
        end
        b_wr = 1'b0;
        tick();
        checks++; if ({b_dout, b_count} !== {8'h4D, 3'd1}) begin
            errors++; $display("FAIL fwft_last got dout=%h cnt=%0d exp 4d 1", b_dout, b_count); end
        tick();
        b_rd = 1'b0;
        checks++; if ({b_dout, b_empty, b_udf} !== {8'h00, 1'b1, 1'b0}) begin
            errors++; $display("FAIL fwft_empty got dout=%h e=%b udf=%b exp 00 1 0", b_dout, b_empty, b_udf); end
    endtask

    task automatic test_flush();
        a_wr = 1'b1;
        for (int i = 0; i < 17; i++) begin
            a_din = 8'(8'h20 + i);
            tick();
        end
        a_wr = 1'b0; a_rd = 1'b1;
        for (int i = 0; i < 9; i++) tick();
        a_rd = 1'b0;
        checks++; if ({a_count, a_ovf, a_udf, a_dout} !== {5'd7, 1'b1, 1'b1, 8'h28}) begin
            errors++; $display("FAIL pre_flush got cnt=%0d ovf=%b udf=%b dout=%h exp 7 1 1 28", a_count, a_ovf, a_udf, a_dout); end
        a_flush = 1'b1; a_wr = 1'b1; a_din = 8'hEE;
        tick();
        a_flush = 1'b0; a_din = 8'h77;
        checks++; if ({a_count, a_empty, a_ovf, a_udf, a_dout} !== {5'd0, 1'b1, 1'b0, 1'b0, 8'h28}) begin
            errors++; $display("FAIL flush got cnt=%0d e=%b ovf=%b udf=%b dout=%h exp 0 1 0 0 28", a_count, a_empty, a_ovf,
                               a_udf, a_dout); end
        tick();
        a_wr = 1'b0; a_rd = 1'b1;
        tick();
        a_rd = 1'b0;
        checks++; if ({a_dout, a_count} !== {8'h77, 5'd0}) begin
            errors++; $display("FAIL flush_discard got dout=%h cnt=%0d exp 77 0", a_dout, a_count); end
    endtask

    task automatic test_async_reset();
        a_wr = 1'b1; b_wr = 1'b1; a_din = 8'h90; b_din = 8'h91;
        tick();
        tick();
        #2;
        rst_ = 1'b0;
        #1;
        checks++; if ({a_count, a_empty, a_full, a_ae, a_dout, a_ovf, a_udf} !== {5'd0, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0}) begin
            errors++; $display("FAIL async_reset got cnt=%0d e=%b f=%b ae=%b dout=%h ovf=%b udf=%b exp 0 1 0 1 00 0 0",
                               a_count, a_empty, a_full, a_ae, a_dout, a_ovf, a_udf); end
        checks++; if ({b_count, b_empty, b_dout} !== {3'd0, 1'b1, 8'h00}) begin
            errors++; $display("FAIL async_reset_fwft got cnt=%0d e=%b dout=%h exp 0 1 00", b_count, b_empty, b_dout); end
        a_wr = 1'b0; b_wr = 1'b0;
        #4;
        rst_ = 1'b1;
        tick();
        checks++; if ({a_count, a_empty} !== {5'd0, 1'b1}) begin
            errors++; $display("FAIL post_reset got cnt=%0d e=%b exp 0 1", a_count, a_empty); end
    endtask

    initial begin
        test_reset();
        test_fill_overflow();
        test_drain_underflow();
        test_full_rw();
        test_empty_rw();
        test_fwft_wrap();
        test_flush();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

endmodule
